spi_slave_param: RTL

Parametrised SPI slave for the SPI-to-RAM path. Deserialises MOSI frames of DATA_W+2 bits (2 command bits plus DATA_W payload) into `rx_data` with a one-cycle `rx_valid` strobe. Serialises RAM read data from `tx_data` onto MISO. Over the fixed 8-bit predecessor it adds a configurable width and bit order, abort detection with a `frame_err` strobe, and a `busy` indicator; it sits between the external SPI master pins and the RAM command interface.

---
 rtl/spi_slave_pkg.sv | 38 +++
 rtl/spi_tx_shifter.sv | 64 ++++++
 rtl/spi_slave_param.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave on the SPI-to-RAM path.
// Contents:
//   - FSM state encodings and the state enum built from them
//   - route bit values sampled in CHK_CMD
//   - two-bit command codes carried in the top bits of every frame
package spi_slave_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CHK_CMD   = 3'd1;
    localparam logic [2:0] ST_WRITE     = 3'd2;
    localparam logic [2:0] ST_READ_ADD  = 3'd3;
    localparam logic [2:0] ST_READ_DATA = 3'd4;
    localparam logic [2:0] ST_TX_WAIT   = 3'd5;
    localparam logic [2:0] ST_TX_SHIFT  = 3'd6;
    localparam logic [2:0] ST_WAIT_END  = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        CHK_CMD   = ST_CHK_CMD,
        WRITE     = ST_WRITE,
        READ_ADD  = ST_READ_ADD,
        READ_DATA = ST_READ_DATA,
        TX_WAIT   = ST_TX_WAIT,
        TX_SHIFT  = ST_TX_SHIFT,
        WAIT_END  = ST_WAIT_END
    } state_e;

    // Route bit: first MOSI bit after SS_n falls.
    localparam logic ROUTE_WR = 1'b0;
    localparam logic ROUTE_RD = 1'b1;

    // Command field {cmd[1:0]} in the top two frame bits.
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO serialiser for RAM read data.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : latch data_i and drive its first bit on miso_o
//   shift_i    : drive the next remaining bit on miso_o
//   clear_i    : drop remaining bits, miso_o low (highest priority)
//   data_i     : parallel word to send
//   miso_o     : registered serial output
module spi_tx_shifter #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o
);

    // shreg_q holds only the bits not yet driven, aligned so the next one
    // sits at the end that is sent first.
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              miso_q,  miso_d;

    always_comb begin
        shreg_d = shreg_q;
        miso_d  = miso_q;
        if (clear_i) begin
            shreg_d = '0;
            miso_d  = 1'b0;
        end else if (load_i) begin
            if (MSB_FIRST) begin
                miso_d  = data_i[DATA_W-1];
                shreg_d = {data_i[DATA_W-2:0], 1'b0};
            end else begin
                miso_d  = data_i[0];
                shreg_d = {1'b0, data_i[DATA_W-1:1]};
            end
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                miso_d  = shreg_q[DATA_W-1];
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            end else begin
                miso_d  = shreg_q[0];
                shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            miso_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            miso_q  <= miso_d;
        end
    end

    assign miso_o = miso_q;

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave between the external SPI master pins and the RAM
// command interface. Receives {route, cmd[1:0], payload} on MOSI, returns
// RAM read data on MISO after a read-data frame.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   SS_n, MOSI, MISO    : SPI pins (SS_n active low)
//   rx_data, rx_valid   : received frame and its one-cycle strobe
//   tx_data, tx_valid   : RAM read data, accepted only while waiting for it
//   frame_err           : one-cycle strobe when SS_n aborts a frame
//   busy                : high whenever the FSM is not idle
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [DATA_W+1:0]   rx_data,
    output logic                rx_valid,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid,
    output logic                frame_err,
    output logic                busy
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(DATA_W - 1);

    state_e               state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [FRAME_W-1:0]   rx_shift_q, rx_shift_d;
    logic [FRAME_W-1:0]   rx_data_q,  rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rd_seen_q,  rd_seen_d;
    logic [FRAME_W-1:0]   rx_in;
    logic                 tx_load, tx_shift, tx_clear;

    // Shift register contents after taking the current MOSI bit.
    always_comb begin
        if (MSB_FIRST) rx_in = {rx_shift_q[FRAME_W-2:0], MOSI};
        else           rx_in = {MOSI, rx_shift_q[FRAME_W-1:1]};
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        rd_seen_d   = rd_seen_q;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;
        tx_clear    = 1'b0;

        if (state_q != IDLE && SS_n) begin
            // Deselect wins over everything, including a last-bit sample.
            // Leaving WAIT_END is a normal end; so is leaving TX_SHIFT once
            // its final bit has already been driven.
            state_d     = IDLE;
            tx_clear    = 1'b1;
            frame_err_d = (state_q != WAIT_END) &&
                          !(state_q == TX_SHIFT && cnt_q == TX_LAST);
        end else begin
            unique case (state_q)
                IDLE: if (!SS_n) state_d = CHK_CMD;
                CHK_CMD: begin
                    if (MOSI == ROUTE_WR) state_d = WRITE;
                    else if (rd_seen_q)   state_d = READ_DATA;
                    else                  state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    rx_shift_d = rx_in;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == FRAME_LAST) begin
                        rx_data_d  = rx_in;
                        rx_valid_d = 1'b1;
                        if (state_q == READ_DATA) begin
                            rd_seen_d = 1'b0;
                            state_d   = TX_WAIT;
                        end else begin
                            if (state_q == READ_ADD) rd_seen_d = 1'b1;
                            state_d = WAIT_END;
                        end
                    end
                end
                TX_WAIT: begin
                    if (tx_valid) begin
                        tx_load = 1'b1;
                        state_d = TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (cnt_q == TX_LAST) begin
                        tx_clear = 1'b1;
                        state_d  = WAIT_END;
                    end else begin
                        tx_shift = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                WAIT_END: ;
                default: state_d = IDLE;
            endcase
        end

        // Counter restarts on every state entry.
        if (state_d != state_q) cnt_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rd_seen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rd_seen_q   <= rd_seen_d;
        end
    end

    spi_tx_shifter #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tx_load),
        .shift_i (tx_shift),
        .clear_i (tx_clear),
        .data_i  (tx_data),
        .miso_o  (MISO)
    );

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
